// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - sequential RV32M/RV64M multiply/divide unit
//
// Iterative shift-add multiplier and restoring divider, one bit per cycle,
// with a start/busy/done handshake so the core can stall on M-extension ops.
//
// Optional feature macro: MULDIV_FAST_SPECIAL_EN
//   When defined, divide-by-zero, signed overflow and multiply-by-zero skip
//   the iterative CALC phase and complete shortly after acceptance.
//
// Parameters:
//   XLEN    operand/result width (32 or 64)
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   operation request, sampled only in IDLE
//   flush   abort the operation in flight (also blocks acceptance)
//   op      funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   src_a   rs1 operand
//   src_b   rs2 operand
//   busy    high whenever the unit is not idle
//   done    one-cycle pulse, result valid
//   result  operation result, held until the next accepted start

module alu_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q;       // negate product / quotient in FIX
  logic              neg_rem_q;   // negate remainder in FIX
  logic [2*XLEN-1:0] mcand_q;     // multiplicand, shifted left each step
  logic [XLEN-1:0]   mplier_q;    // multiplier, shifted right each step
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   quot_q;      // starts as dividend, fills with quotient bits
  logic [XLEN:0]     rem_q;
  logic [XLEN-1:0]   dvsr_q;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   result_q;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

  // Acceptance and operand sign handling
  logic            accept;
  logic            a_signed, b_signed, a_neg, b_neg, b_zero;
  logic [XLEN-1:0] a_mag, b_mag;

  assign accept   = (state_q == S_IDLE) && start && !flush;
  assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign a_neg    = a_signed && src_a[XLEN-1];
  assign b_neg    = b_signed && src_b[XLEN-1];
  assign a_mag    = a_neg ? -src_a : src_a;
  assign b_mag    = b_neg ? -src_b : src_b;
  assign b_zero   = (src_b == '0);

  // Short-circuit results for the special cases; the regular datapath is
  // preloaded so that FIX (with sign flags cleared) yields these directly.
  logic            fast_hit;
  logic [XLEN-1:0] fast_quot, fast_rem;
`ifdef MULDIV_FAST_SPECIAL_EN
  logic sgn_ovf;
  assign sgn_ovf   = ((op == OP_DIV) || (op == OP_REM)) &&
                     (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
  assign fast_hit  = op[2] ? (b_zero || sgn_ovf) : (b_zero || (src_a == '0));
  assign fast_quot = b_zero ? '1 : src_a;
  assign fast_rem  = b_zero ? src_a : '0;
`else
  assign fast_hit  = 1'b0;
  assign fast_quot = '0;
  assign fast_rem  = '0;
`endif

  // One multiply step and one restoring-divide step
  logic [2*XLEN-1:0] mul_sum;
  logic [XLEN+1:0]   rem_sh, rem_diff;
  logic              q_bit;
  logic              last_step;

  assign mul_sum   = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign rem_sh    = {rem_q, quot_q[XLEN-1]};
  assign rem_diff  = rem_sh - {2'b00, dvsr_q};
  assign q_bit     = !rem_diff[XLEN+1];        // no borrow: divisor fits
  assign last_step = (cnt_q == CW'(XLEN - 1));

  // Sign correction and result selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, result_fix;

  always_comb begin
    prod_fix = neg_q ? -prod_q : prod_q;
    quot_fix = neg_q ? -quot_q : quot_q;
    rem_fix  = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    case (op_q)
      OP_MUL:                      result_fix = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_fix = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             result_fix = quot_fix;
      default:                     result_fix = rem_fix;
    endcase
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = fast_hit ? S_FIX : S_CALC;
      S_CALC: if (last_step) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_q == S_FIX) && (state_d == S_DONE);

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q      <= op;
            cnt_q     <= '0;
            // Divide by zero returns all ones unsigned, so its quotient
            // must not be sign-corrected.
            neg_q     <= (a_neg ^ b_neg) && !(op[2] && b_zero);
            neg_rem_q <= a_neg;
            mcand_q   <= {{XLEN{1'b0}}, a_mag};
            mplier_q  <= b_mag;
            prod_q    <= '0;
            quot_q    <= a_mag;
            rem_q     <= '0;
            dvsr_q    <= b_mag;
            if (fast_hit) begin
              neg_q     <= 1'b0;
              neg_rem_q <= 1'b0;
              quot_q    <= fast_quot;
              rem_q     <= {1'b0, fast_rem};
            end
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + CW'(1);
          if (op_q[2]) begin
            quot_q <= {quot_q[XLEN-2:0], q_bit};
            rem_q  <= q_bit ? rem_diff[XLEN:0] : rem_sh[XLEN:0];
          end else begin
            prod_q   <= mul_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
          end
        end
        S_FIX: begin
          if (!flush) result_q <= result_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - self-checking bench for alu_muldiv_seq
module tb_alu_muldiv_seq;

  localparam int XLEN = 32;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
  localparam logic [31:0] MINV = 32'h8000_0000;

  // Rising edges after the start-sampling edge until done is seen
  // (the start edge itself makes XLEN+2 in total).
  localparam int LAT_FULL = XLEN + 1;
`ifdef MULDIV_FAST_SPECIAL_EN
  localparam int LAT_FAST = 1;
`else
  localparam int LAT_FAST = LAT_FULL;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        busy, done;
  logic [31:0] result;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .result(result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p, ua;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ua = {32'b0, a};
    case (o)
      MUL:    begin p = sa * sb; return p[31:0];  end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = ua * {32'b0, b}; return p[63:32]; end
      DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM:    begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o >= DIV)
      return (b == 0) || (((o == DIV) || (o == REM)) && (a == MINV) && (b == 32'hFFFF_FFFF));
    return (a == 0) || (b == 0);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return MINV;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Runs one operation. poke_at/flush_at: cycle index after acceptance at
  // which to pulse start or flush (-1 = never). start_on_done raises start
  // during the done cycle, which must not be accepted.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int poke_at, input int flush_at,
                       input bit start_on_done);
    int edges;
    int exp_lat;
    bit seen_done;
    bit busy_ok;
    bit late_done;
    exp_lat = is_special(o, a, b) ? LAT_FAST : LAT_FULL;
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom); src_a = $urandom; src_b = $urandom;
    busy_ok = busy;
    edges = 0;
    seen_done = 1'b0;
    while (edges < 100 && !seen_done) begin
      if (edges == poke_at) start = 1'b1;
      if (edges == flush_at) flush = 1'b1;
      @(posedge clk); #1;
      edges++;
      start = 1'b0;
      if (flush) begin
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_result", 64'(result), 64'(last_res));
        late_done = 1'b0;
        repeat (XLEN + 4) begin
          @(posedge clk); #1;
          if (done) late_done = 1'b1;
        end
        check("flush_no_done", 64'(late_done), 64'd0);
        return;
      end
      if (done) seen_done = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    check("done_seen", 64'(seen_done), 64'd1);
    check("latency", 64'(edges), 64'(exp_lat));
    check("busy_held", 64'(busy_ok && busy), 64'd1);
    check("result", 64'(result), 64'(exp));
    if (start_on_done) begin
      start = 1'b1; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse", 64'(done), 64'd0);
    check("idle_after", 64'(busy), 64'd0);
    if (seen_done) last_res = exp;
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    bit          abort_ok;

    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_op(MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, -1, -1, 1'b0);
    do_op(MULH,   MINV,           MINV,          32'h4000_0000, -1, -1, 1'b0);
    do_op(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, -1, -1, 1'b0);
    do_op(MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, -1, -1, 1'b0);
    do_op(DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, -1, -1, 1'b0);
    do_op(REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, -1, -1, 1'b0);
    do_op(DIVU,   32'd100,        32'd7,         32'd14,        -1, -1, 1'b0);
    do_op(REMU,   32'd100,        32'd7,         32'd2,         -1, -1, 1'b0);
    do_op(DIVU,   32'h1234,       32'd0,         32'hFFFF_FFFF, -1, -1, 1'b0);
    do_op(REM,    32'h1234,       32'd0,         32'h1234,      -1, -1, 1'b0);
    do_op(DIV,    32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFFF, -1, -1, 1'b0);
    do_op(DIV,    MINV,           32'hFFFF_FFFF, MINV,          -1, -1, 1'b0);
    do_op(REM,    MINV,           32'hFFFF_FFFF, 32'd0,         -1, -1, 1'b0);
    do_op(MUL,    32'd0,          32'h1234_5678, 32'd0,         -1, -1, 1'b0);

    // Start while busy is ignored; start during done is ignored
    do_op(DIV,    32'd1000,       32'd7,         32'd142,        4, -1, 1'b1);
    // Flush mid-calculation: no done, result keeps the previous value
    do_op(DIV,    32'd5000,       32'd3,         32'd1666,      -1,  9, 1'b0);

    // Asynchronous reset mid-CALC
    op = DIV; src_a = 32'd77777; src_b = 32'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("areset_busy", 64'(busy), 64'd0);
    check("areset_done", 64'(done), 64'd0);
    check("areset_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    @(posedge clk); #1;
    do_op(MUL, 32'd3, 32'd5, 32'd15, -1, -1, 1'b0);

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      do_op(o, a, b, model(o, a, b), -1, -1, ($urandom_range(0, 3) == 0));
    end

    abort_ok = 1'b1;
    if (!abort_ok) check("unreachable", 64'd0, 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
